systolic_mm_ctrl: RTL and testbench

- Sequencer for the 3x3 systolic matrix-multiply array.
- Holds operand matrices A and B, which are loaded through a simple write port. On start it clears the array accumulators and feeds rows of A and columns of B with diagonal skew.
- Waits for the wavefront to drain, then captures the 9 cell results into a readable result buffer and pulses done.
- Sits between the host/bus side and the array instance.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_skew_feed.sv | 66 ++++++
 rtl/systolic_mm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_systolic_mm_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the 3x3 systolic matrix-multiply sequencer.
package systolic_pkg;
  localparam int N           = 3;
  localparam int NCELLS      = N * N;
  localparam int FEED_CYCLES = 2 * N - 1;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE
  } state_t;
endpackage

// File: rtl/systolic_skew_feed.sv
// Diagonally skewed edge feeds: row r of A and column c of B enter the array r (or c) cycles late.
module systolic_skew_feed
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TW         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         feed_en,
  input  logic [TW-1:0]                t,
  input  logic [NCELLS*DATA_WIDTH-1:0] a_flat,
  input  logic [NCELLS*DATA_WIDTH-1:0] b_flat,
  output logic [N*DATA_WIDTH-1:0]      a_feed,
  output logic [N*DATA_WIDTH-1:0]      b_feed
);
  localparam int IW = $clog2(N);

  logic [DATA_WIDTH-1:0] a_m [N][N];
  logic [DATA_WIDTH-1:0] b_m [N][N];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        assign a_m[gi][gj] = a_flat[(gi*N + gj)*DATA_WIDTH +: DATA_WIDTH];
        assign b_m[gi][gj] = b_flat[(gi*N + gj)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_edge
      logic [TW-1:0]         diff;
      logic                  in_window;
      logic [DATA_WIDTH-1:0] a_next;
      logic [DATA_WIDTH-1:0] b_next;
      logic [DATA_WIDTH-1:0] a_reg;
      logic [DATA_WIDTH-1:0] b_reg;

      // diff is the operand index k this edge presents at feed step t
      assign diff      = t - TW'(gi);
      assign in_window = feed_en && (t >= TW'(gi)) && (diff < TW'(N));

      always_comb begin
        a_next = '0;
        b_next = '0;
        if (in_window) begin
          a_next = a_m[gi][diff[IW-1:0]];
          b_next = b_m[diff[IW-1:0]][gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else begin
          a_reg <= a_next;
          b_reg <= b_next;
        end
      end

      assign a_feed[gi*DATA_WIDTH +: DATA_WIDTH] = a_reg;
      assign b_feed[gi*DATA_WIDTH +: DATA_WIDTH] = b_reg;
    end
  endgenerate
endmodule

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for a 3x3 systolic array: operand storage, clear/feed/drain/capture FSM, result buffer.
module systolic_mm_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_en,
  input  logic                    i_wr_sel,
  input  logic [3:0]              i_wr_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_arr_rst,
  output logic [DATA_WIDTH-1:0]   o_A1,
  output logic [DATA_WIDTH-1:0]   o_A4,
  output logic [DATA_WIDTH-1:0]   o_A7,
  output logic [DATA_WIDTH-1:0]   o_B1,
  output logic [DATA_WIDTH-1:0]   o_B2,
  output logic [DATA_WIDTH-1:0]   o_B3,
  input  logic [2*DATA_WIDTH:0]   i_cell_1,
  input  logic [2*DATA_WIDTH:0]   i_cell_2,
  input  logic [2*DATA_WIDTH:0]   i_cell_3,
  input  logic [2*DATA_WIDTH:0]   i_cell_4,
  input  logic [2*DATA_WIDTH:0]   i_cell_5,
  input  logic [2*DATA_WIDTH:0]   i_cell_6,
  input  logic [2*DATA_WIDTH:0]   i_cell_7,
  input  logic [2*DATA_WIDTH:0]   i_cell_8,
  input  logic [2*DATA_WIDTH:0]   i_cell_9,
  input  logic [3:0]              i_rd_addr,
  output logic [2*DATA_WIDTH:0]   o_rd_data
);
  localparam int RW      = 2 * DATA_WIDTH + 1;
  localparam int CNT_MAX = (FEED_CYCLES > DRAIN_CYCLES) ? FEED_CYCLES : DRAIN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  state_t                        state_reg, state_next;
  logic [CW-1:0]                 cnt_reg, cnt_next;
  logic                          arr_rst_reg;
  logic                          done_reg;
  logic [RW-1:0]                 rd_data_reg;
  logic                          wr_ok;
  logic [NCELLS*DATA_WIDTH-1:0]  a_flat;
  logic [NCELLS*DATA_WIDTH-1:0]  b_flat;
  logic [N*DATA_WIDTH-1:0]       a_feed;
  logic [N*DATA_WIDTH-1:0]       b_feed;
  logic [NCELLS-1:0][RW-1:0]     cells;
  logic [NCELLS-1:0][RW-1:0]     res_all;

  assign cells = {i_cell_9, i_cell_8, i_cell_7, i_cell_6, i_cell_5,
                  i_cell_4, i_cell_3, i_cell_2, i_cell_1};

  // Operands are frozen while a run is in flight so the feed never sees a torn matrix
  assign wr_ok = (state_reg == IDLE) && i_wr_en && (i_wr_addr < 4'(NCELLS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      arr_rst_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      arr_rst_reg <= (state_next == CLEAR);
      done_reg    <= (state_reg == CAPTURE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) state_next = CLEAR;
      end
      CLEAR: begin
        state_next = FEED;
        cnt_next   = '0;
      end
      FEED: begin
        if (cnt_reg == CW'(FEED_CYCLES - 1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_reg == CW'(DRAIN_CYCLES - 1)) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCELLS; gi++) begin : g_cell
      logic [DATA_WIDTH-1:0] a_reg;
      logic [DATA_WIDTH-1:0] b_reg;
      logic [RW-1:0]         res_reg;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_reg   <= '0;
          b_reg   <= '0;
          res_reg <= '0;
        end else begin
          if (wr_ok && (i_wr_addr == 4'(gi))) begin
            if (i_wr_sel == SEL_A) a_reg <= i_wr_data;
            else                   b_reg <= i_wr_data;
          end
          if (state_reg == CAPTURE) res_reg <= cells[gi];
        end
      end

      assign a_flat[gi*DATA_WIDTH +: DATA_WIDTH] = a_reg;
      assign b_flat[gi*DATA_WIDTH +: DATA_WIDTH] = b_reg;
      assign res_all[gi]                         = res_reg;
    end
  endgenerate

  // Feeds are driven from the next-state view so the registered outputs line up with FEED step t
  systolic_skew_feed #(
    .DATA_WIDTH (DATA_WIDTH),
    .TW         (CW)
  ) u_skew_feed (
    .clk     (i_clk),
    .rst     (i_rst),
    .feed_en (state_next == FEED),
    .t       (cnt_next),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .a_feed  (a_feed),
    .b_feed  (b_feed)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= (i_rd_addr < 4'(NCELLS)) ? res_all[i_rd_addr] : '0;
    end
  end

  assign o_busy    = (state_reg != IDLE);
  assign o_done    = done_reg;
  assign o_arr_rst = arr_rst_reg;
  assign o_rd_data = rd_data_reg;
  assign o_A1      = a_feed[0*DATA_WIDTH +: DATA_WIDTH];
  assign o_A4      = a_feed[1*DATA_WIDTH +: DATA_WIDTH];
  assign o_A7      = a_feed[2*DATA_WIDTH +: DATA_WIDTH];
  assign o_B1      = b_feed[0*DATA_WIDTH +: DATA_WIDTH];
  assign o_B2      = b_feed[1*DATA_WIDTH +: DATA_WIDTH];
  assign o_B3      = b_feed[2*DATA_WIDTH +: DATA_WIDTH];
endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: a behavioural 3x3 array sits behind the feeds, results are checked
// against a plain matrix product (mod 2^RW) computed from the bench's copy of the operands.
module tb_systolic_mm_ctrl;
  localparam int DW = 8;
  localparam int RW = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic          busy, done, arr_rst;
  logic [DW-1:0] a1, a4, a7, b1, b2, b3;
  logic [RW-1:0] rd_data;
  logic [RW-1:0] acc [9];

  int checks = 0;
  int failures = 0;
  int am [9];
  int bm [9];

  systolic_mm_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .o_busy(busy), .o_done(done), .o_arr_rst(arr_rst),
    .o_A1(a1), .o_A4(a4), .o_A7(a7), .o_B1(b1), .o_B2(b2), .o_B3(b3),
    .i_cell_1(acc[0]), .i_cell_2(acc[1]), .i_cell_3(acc[2]),
    .i_cell_4(acc[3]), .i_cell_5(acc[4]), .i_cell_6(acc[5]),
    .i_cell_7(acc[6]), .i_cell_8(acc[7]), .i_cell_9(acc[8]),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary array: A flows right, B flows down, each cell accumulates a*b.
  logic [DW-1:0] fa [3];
  logic [DW-1:0] fb [3];
  logic [DW-1:0] ah [3][3];
  logic [DW-1:0] bv [3][3];
  assign fa[0] = a1; assign fa[1] = a4; assign fa[2] = a7;
  assign fb[0] = b1; assign fb[1] = b2; assign fb[2] = b3;

  function automatic logic [DW-1:0] a_in_of(int r, int c);
    if (c == 0) return fa[r];
    return ah[r][c-1];
  endfunction

  function automatic logic [DW-1:0] b_in_of(int r, int c);
    if (r == 0) return fb[c];
    return bv[r-1][c];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || arr_rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          ah[r][c] <= '0;
          bv[r][c] <= '0;
          acc[r*3+c] <= '0;
        end
    end else begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          acc[r*3+c] <= acc[r*3+c] + RW'(a_in_of(r, c)) * RW'(b_in_of(r, c));
          ah[r][c] <= a_in_of(r, c);
          bv[r][c] <= b_in_of(r, c);
        end
    end
  end

  function automatic logic [RW-1:0] expc(int idx);
    longint s = 0;
    for (int k = 0; k < 3; k++) s += longint'(am[(idx/3)*3+k]) * longint'(bm[k*3+(idx%3)]);
    return RW'(s);
  endfunction

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int k = 0; k < 9; k++) wr(1'b0, 4'(k), DW'(am[k]));
    for (int k = 0; k < 9; k++) wr(1'b1, 4'(k), DW'(bm[k]));
  endtask

  // Returns the cycle (counted from the start-sampling edge) in which done is seen, -1 on timeout
  task automatic run(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
    $display("run: done in cycle %0d", cyc);
  endtask

  task automatic rd(input int idx, output logic [RW-1:0] v);
    rd_addr = 4'(idx);
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic test_reset();
    logic [RW-1:0] v;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (arr_rst !== 1'b0) begin failures++; $display("FAIL reset_arr_rst: got %b expected 0", arr_rst); end
    checks++; if ({a1, a4, a7, b1, b2, b3} !== '0) begin failures++; $display("FAIL reset_feeds: got %h expected 0", {a1, a4, a7, b1, b2, b3}); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin am[k] = 0; bm[k] = 0; end
    rd(4, v);
    checks++; if (v !== '0) begin failures++; $display("FAIL reset_result: got %0d expected 0", v); end
    $display("test_reset done");
  endtask

  task automatic test_matrix(input string name, input int mode);
    int cyc;
    logic [RW-1:0] v;
    for (int k = 0; k < 9; k++) begin
      case (mode)
        0: begin am[k] = k + 1; bm[k] = (k % 4 == 0) ? 1 : 0; end
        1: begin am[k] = k + 1; bm[k] = 9 - k; end
        2: begin am[k] = 255; bm[k] = 255; end
        default: begin am[k] = $urandom_range(0, 255); bm[k] = $urandom_range(0, 255); end
      endcase
    end
    load_all();
    run(cyc);
    checks++; if (cyc !== 11) begin failures++; $display("FAIL %s_latency: got %0d expected 11", name, cyc); end
    for (int k = 0; k < 9; k++) begin
      rd(k, v);
      checks++;
      if (v !== expc(k)) begin failures++; $display("FAIL %s_result[%0d]: got %0d expected %0d", name, k, v, expc(k)); end
    end
    for (int k = 9; k < 16; k++) begin
      rd(k, v);
      checks++;
      if (v !== '0) begin failures++; $display("FAIL %s_rd_oob[%0d]: got %0d expected 0", name, k, v); end
    end
    $display("%s: A[0]=%0d B[0]=%0d C[8]=%0d", name, am[0], bm[0], expc(8));
  endtask

  task automatic test_feed_skew();
    int t;
    int ea [3];
    int eb [3];
    for (int k = 0; k < 9; k++) begin am[k] = $urandom_range(1, 255); bm[k] = $urandom_range(1, 255); end
    load_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      t = cyc - 2;
      for (int r = 0; r < 3; r++) begin
        ea[r] = (t - r >= 0 && t - r <= 2 && t <= 4) ? am[r*3 + (t - r)] : 0;
        eb[r] = (t - r >= 0 && t - r <= 2 && t <= 4) ? bm[(t - r)*3 + r] : 0;
        checks++;
        if (int'(fa[r]) !== ea[r]) begin failures++; $display("FAIL feed_A_row%0d_cyc%0d: got %0d expected %0d", r, cyc, fa[r], ea[r]); end
        checks++;
        if (int'(fb[r]) !== eb[r]) begin failures++; $display("FAIL feed_B_col%0d_cyc%0d: got %0d expected %0d", r, cyc, fb[r], eb[r]); end
      end
      checks++;
      if (arr_rst !== (cyc == 1)) begin failures++; $display("FAIL feed_arr_rst_cyc%0d: got %b expected %b", cyc, arr_rst, cyc == 1); end
      checks++;
      if (busy !== (cyc <= 10)) begin failures++; $display("FAIL feed_busy_cyc%0d: got %b expected %b", cyc, busy, cyc <= 10); end
      checks++;
      if (done !== (cyc == 11)) begin failures++; $display("FAIL feed_done_cyc%0d: got %b expected %b", cyc, done, cyc == 11); end
      @(negedge clk);
    end
    $display("test_feed_skew done");
  endtask

  task automatic test_busy_ignore();
    int cyc;
    int extra_done = 0;
    int extra_busy = 0;
    logic [RW-1:0] v;
    logic [RW-1:0] first [9];
    for (int k = 0; k < 9; k++) begin am[k] = $urandom_range(0, 255); bm[k] = $urandom_range(0, 255); end
    load_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin @(negedge clk); cyc++; end
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = ~DW'(am[0]);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    cyc++;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 11) begin failures++; $display("FAIL busy_latency: got %0d expected 11", cyc); end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    checks++; if (extra_done !== 0) begin failures++; $display("FAIL busy_no_restart_done: got %0d pulses expected 0", extra_done); end
    checks++; if (extra_busy !== 0) begin failures++; $display("FAIL busy_no_restart_busy: got %0d cycles expected 0", extra_busy); end
    for (int k = 0; k < 9; k++) begin
      rd(k, first[k]);
      checks++;
      if (first[k] !== expc(k)) begin failures++; $display("FAIL busy_run1[%0d]: got %0d expected %0d", k, first[k], expc(k)); end
    end
    wr(1'b0, 4'd9, 8'hA5);
    wr(1'b1, 4'd15, 8'h5A);
    run(cyc);
    checks++; if (cyc !== 11) begin failures++; $display("FAIL busy_rerun_latency: got %0d expected 11", cyc); end
    for (int k = 0; k < 9; k++) begin
      rd(k, v);
      checks++;
      if (v !== first[k] || v !== expc(k)) begin failures++; $display("FAIL busy_rerun[%0d]: got %0d expected %0d", k, v, expc(k)); end
    end
    $display("test_busy_ignore done");
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int seen_done = 0;
    logic [RW-1:0] v;
    for (int k = 0; k < 9; k++) begin am[k] = $urandom_range(1, 255); bm[k] = $urandom_range(1, 255); end
    load_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin @(negedge clk); cyc++; end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (arr_rst !== 1'b0) begin failures++; $display("FAIL midrst_arr_rst: got %b expected 0", arr_rst); end
    checks++; if ({a1, a4, a7, b1, b2, b3} !== '0) begin failures++; $display("FAIL midrst_feeds: got %h expected 0", {a1, a4, a7, b1, b2, b3}); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL midrst_rd_data: got %0d expected 0", rd_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin am[k] = 0; bm[k] = 0; end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen_done); end
    for (int k = 0; k < 9; k++) begin
      rd(k, v);
      checks++;
      if (v !== '0) begin failures++; $display("FAIL midrst_result[%0d]: got %0d expected 0", k, v); end
    end
    run(cyc);
    checks++; if (cyc !== 11) begin failures++; $display("FAIL midrst_rerun_latency: got %0d expected 11", cyc); end
    for (int k = 0; k < 9; k++) begin
      rd(k, v);
      checks++;
      if (v !== expc(k)) begin failures++; $display("FAIL midrst_rerun[%0d]: got %0d expected %0d", k, v, expc(k)); end
    end
    $display("test_reset_midrun done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_matrix("identity", 0);
    test_matrix("product", 1);
    test_matrix("full_width", 2);
    for (int i = 0; i < 3; i++) test_matrix("random", 3);
    test_feed_skew();
    test_busy_ignore();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
